// File: rtl/pe_pkg.sv
// Shared types and helpers for the double-buffered weight-stationary PE.
package pe_pkg;

  typedef enum logic {
    ModeUnsigned = 1'b0,
    ModeSigned   = 1'b1
  } pe_mode_e;

  localparam int unsigned DATAWIDTH_DEFAULT = 8;
  localparam int unsigned PROD_W = 2 * DATAWIDTH_DEFAULT;
  localparam int unsigned BOUND_W = 65;

  typedef struct packed {
    logic [BOUND_W-1:0] max_v;
    logic [BOUND_W-1:0] min_v;
  } sat_bounds_t;

  // Bounds are returned as two's-complement bit patterns; callers keep the low width bits.
  function automatic sat_bounds_t sat_bounds(input int unsigned width, input logic is_signed);
    sat_bounds_t b;
    logic [BOUND_W-1:0] one;
    one = BOUND_W'(1);
    if (is_signed) begin
      b.max_v = (one << (width - 1)) - one;
      b.min_v = ~b.max_v;
    end else begin
      b.max_v = (one << width) - one;
      b.min_v = '0;
    end
    return b;
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational multiply, extend, accumulate and clamp. The product is exposed so the
// caller can register it between the multiply and the add.
module pe_mac_sat import pe_pkg::*; #(
  parameter int unsigned DATAWIDTH        = DATAWIDTH_DEFAULT,
  parameter int unsigned DATAWIDTH_output = 32,
  parameter int unsigned PROD_WIDTH       = PROD_W,
  parameter pe_mode_e    MODE             = ModeSigned,
  parameter bit          SATURATE         = 1'b1
) (
  input  logic [DATAWIDTH-1:0]        a,
  input  logic [DATAWIDTH-1:0]        w,
  output logic [PROD_WIDTH-1:0]       prod,
  input  logic [PROD_WIDTH-1:0]       prod_in,
  input  logic [DATAWIDTH_output-1:0] b,
  output logic [DATAWIDTH_output-1:0] sum,
  output logic                        ovf
);

  localparam int unsigned SW = DATAWIDTH_output + 1;
  localparam int unsigned XW = PROD_WIDTH - DATAWIDTH;
  localparam bit IsSigned = (MODE == ModeSigned);
  localparam sat_bounds_t Bounds = sat_bounds(DATAWIDTH_output, IsSigned);
  localparam logic [DATAWIDTH_output-1:0] MaxV = Bounds.max_v[DATAWIDTH_output-1:0];
  localparam logic [DATAWIDTH_output-1:0] MinV = Bounds.min_v[DATAWIDTH_output-1:0];

  logic           a_s, w_s, p_s, b_s;
  logic [SW-1:0]  sum_x;

  always_comb begin
    a_s = IsSigned & a[DATAWIDTH-1];
    w_s = IsSigned & w[DATAWIDTH-1];
    // Low PROD_WIDTH bits of the extended operands' product equal the true product.
    prod = {{XW{a_s}}, a} * {{XW{w_s}}, w};

    p_s   = IsSigned & prod_in[PROD_WIDTH-1];
    b_s   = IsSigned & b[DATAWIDTH_output-1];
    sum_x = {{(SW - PROD_WIDTH){p_s}}, prod_in} + {b_s, b};

    if (IsSigned) ovf = sum_x[SW-1] ^ sum_x[SW-2];
    else          ovf = sum_x[SW-1];

    sum = sum_x[DATAWIDTH_output-1:0];
    if (ovf && SATURATE) sum = (IsSigned && sum_x[SW-1]) ? MinV : MaxV;
  end

endmodule

// File: rtl/pe_dbuf.sv
// Weight-stationary PE with shadow/active weight double buffer, daisy-chained weight
// load, optional product pipeline stage and saturating accumulation with sticky overflow.
module pe_dbuf import pe_pkg::*; #(
  parameter int unsigned DATAWIDTH        = DATAWIDTH_DEFAULT,
  parameter int unsigned DATAWIDTH_output = 32,
  parameter int unsigned SIGNED           = 1,
  parameter int unsigned MUL_STAGES       = 1,
  parameter int unsigned SATURATE         = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wt_en,
  input  logic [DATAWIDTH-1:0]        wt_in,
  output logic [DATAWIDTH-1:0]        wt_out,
  input  logic                        wt_swap,
  input  logic                        valid_in,
  input  logic [DATAWIDTH-1:0]        in_A,
  input  logic [DATAWIDTH_output-1:0] in_B,
  output logic [DATAWIDTH_output-1:0] out_D,
  output logic                        valid_out,
  output logic [DATAWIDTH-1:0]        out_R,
  output logic                        valid_r,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int unsigned PW = 2 * DATAWIDTH;
  localparam pe_mode_e Mode = (SIGNED != 0) ? ModeSigned : ModeUnsigned;

  logic [DATAWIDTH-1:0]        shadow_q, active_q;
  logic [PW-1:0]               prod_comb, prod_sel;
  logic [DATAWIDTH_output-1:0] b_sel, sum;
  logic                        v_sel, sum_ovf;

  assign wt_out = shadow_q;

  // Active takes the pre-edge shadow, so a same-cycle load and swap behaves as a shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      out_R    <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (wt_en)   shadow_q <= wt_in;
      if (wt_swap) active_q <= shadow_q;
      out_R   <= in_A;
      valid_r <= valid_in;
    end
  end

  pe_mac_sat #(
    .DATAWIDTH        (DATAWIDTH),
    .DATAWIDTH_output (DATAWIDTH_output),
    .PROD_WIDTH       (PW),
    .MODE             (Mode),
    .SATURATE         (SATURATE != 0)
  ) u_mac (
    .a       (in_A),
    .w       (active_q),
    .prod    (prod_comb),
    .prod_in (prod_sel),
    .b       (b_sel),
    .sum     (sum),
    .ovf     (sum_ovf)
  );

  if (MUL_STAGES == 2) begin : g_pipe
    logic [PW-1:0]               prod_q;
    logic [DATAWIDTH_output-1:0] b_q;
    logic                        v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        b_q    <= '0;
        v_q    <= 1'b0;
      end else begin
        v_q <= valid_in;
        if (valid_in) begin
          prod_q <= prod_comb;
          b_q    <= in_B;
        end
      end
    end

    assign prod_sel = prod_q;
    assign b_sel    = b_q;
    assign v_sel    = v_q;
  end else begin : g_comb
    assign prod_sel = prod_comb;
    assign b_sel    = in_B;
    assign v_sel    = valid_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_D     <= '0;
      valid_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      valid_out <= v_sel;
      if (v_sel) out_D <= sum;
      if (v_sel && sum_ovf) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_dbuf.sv
// Bench for pe_dbuf: five parameterisations share one stimulus stream and are checked
// every cycle against an arithmetic model, plus a three-deep weight chain.
module tb_pe_dbuf;

  localparam int NI = 5;

  logic        clk, rst_n, wt_en, wt_swap, valid_in, ovf_clr;
  logic [7:0]  wt_in, in_A;
  logic [31:0] in_B;

  logic [NI-1:0][31:0] o_D;
  logic [NI-1:0][7:0]  o_R, o_wt;
  logic [NI-1:0]       o_vo, o_vr, o_ov;

  logic [2:0][7:0]  c_wt, c_R;
  logic [2:0][31:0] c_D;
  logic [2:0]       c_vo, c_vr, c_ov;

  // Per-instance configuration: output width, signedness, saturation, latency.
  int cfg_dow [NI] = '{32, 32, 16, 16, 32};
  bit cfg_sg  [NI] = '{1, 0, 1, 1, 1};
  bit cfg_sat [NI] = '{1, 1, 1, 0, 1};
  int cfg_lat [NI] = '{1, 1, 1, 1, 2};

  logic [7:0]  m_sh [NI], m_ac [NI], m_R [NI];
  logic [31:0] m_D [NI], p_d [NI];
  bit          m_vo [NI], m_vr [NI], m_ov [NI], p_v [NI], p_o [NI];

  int n_vec, n_bad;
  bit cmp_en;

  pe_dbuf u0 (.clk(clk), .rst_n(rst_n), .wt_en(wt_en), .wt_in(wt_in), .wt_out(o_wt[0]),
    .wt_swap(wt_swap), .valid_in(valid_in), .in_A(in_A), .in_B(in_B), .out_D(o_D[0]),
    .valid_out(o_vo[0]), .out_R(o_R[0]), .valid_r(o_vr[0]), .ovf(o_ov[0]), .ovf_clr(ovf_clr));

  pe_dbuf #(.SIGNED(0)) u1 (.clk(clk), .rst_n(rst_n), .wt_en(wt_en), .wt_in(wt_in),
    .wt_out(o_wt[1]), .wt_swap(wt_swap), .valid_in(valid_in), .in_A(in_A), .in_B(in_B),
    .out_D(o_D[1]), .valid_out(o_vo[1]), .out_R(o_R[1]), .valid_r(o_vr[1]), .ovf(o_ov[1]),
    .ovf_clr(ovf_clr));

  pe_dbuf #(.DATAWIDTH_output(16)) u2 (.clk(clk), .rst_n(rst_n), .wt_en(wt_en),
    .wt_in(wt_in), .wt_out(o_wt[2]), .wt_swap(wt_swap), .valid_in(valid_in), .in_A(in_A),
    .in_B(in_B[15:0]), .out_D(o_D[2][15:0]), .valid_out(o_vo[2]), .out_R(o_R[2]),
    .valid_r(o_vr[2]), .ovf(o_ov[2]), .ovf_clr(ovf_clr));

  pe_dbuf #(.DATAWIDTH_output(16), .SATURATE(0)) u3 (.clk(clk), .rst_n(rst_n),
    .wt_en(wt_en), .wt_in(wt_in), .wt_out(o_wt[3]), .wt_swap(wt_swap), .valid_in(valid_in),
    .in_A(in_A), .in_B(in_B[15:0]), .out_D(o_D[3][15:0]), .valid_out(o_vo[3]),
    .out_R(o_R[3]), .valid_r(o_vr[3]), .ovf(o_ov[3]), .ovf_clr(ovf_clr));

  pe_dbuf #(.MUL_STAGES(2)) u4 (.clk(clk), .rst_n(rst_n), .wt_en(wt_en), .wt_in(wt_in),
    .wt_out(o_wt[4]), .wt_swap(wt_swap), .valid_in(valid_in), .in_A(in_A), .in_B(in_B),
    .out_D(o_D[4]), .valid_out(o_vo[4]), .out_R(o_R[4]), .valid_r(o_vr[4]), .ovf(o_ov[4]),
    .ovf_clr(ovf_clr));

  assign o_D[2][31:16] = '0;
  assign o_D[3][31:16] = '0;

  // Weight chain: c0 is fed by the loader, c1 and c2 sit below it.
  for (genvar g = 0; g < 3; g++) begin : g_chain
    pe_dbuf uc (.clk(clk), .rst_n(rst_n), .wt_en(wt_en),
      .wt_in((g == 0) ? wt_in : c_wt[(g == 0) ? 0 : g - 1]), .wt_out(c_wt[g]),
      .wt_swap(1'b0), .valid_in(1'b0), .in_A(8'h00), .in_B(32'h0), .out_D(c_D[g]),
      .valid_out(c_vo[g]), .out_R(c_R[g]), .valid_r(c_vr[g]), .ovf(c_ov[g]), .ovf_clr(1'b0));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Exact integer result, then range test and clamp/wrap.
  function automatic void mac(input int i, input logic [7:0] a, input logic [7:0] w,
                              input logic [31:0] b, output logic [31:0] d, output bit ov);
    longint pa, pw, pb, s, lo, hi;
    int dw;
    dw = cfg_dow[i];
    if (cfg_sg[i]) begin
      pa = longint'(byte'(a));
      pw = longint'(byte'(w));
      pb = (dw == 16) ? longint'(shortint'(b[15:0])) : longint'(int'(b));
      lo = -(64'sd1 <<< (dw - 1));
      hi = (64'sd1 <<< (dw - 1)) - 1;
    end else begin
      pa = longint'(a);
      pw = longint'(w);
      pb = (dw == 16) ? longint'(b[15:0]) : longint'(b);
      lo = 0;
      hi = (64'sd1 <<< dw) - 1;
    end
    s  = pa * pw + pb;
    ov = (s < lo) || (s > hi);
    if (ov && cfg_sat[i]) s = (s < lo) ? lo : hi;
    d = (dw == 16) ? {16'h0, s[15:0]} : s[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_sh[i] = '0; m_ac[i] = '0; m_R[i] = '0; m_D[i] = '0; p_d[i] = '0;
      m_vo[i] = 0; m_vr[i] = 0; m_ov[i] = 0; p_v[i] = 0; p_o[i] = 0;
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      logic [31:0] d, cd;
      bit ov, cv, co;
      d = '0;
      ov = 0;
      if (valid_in) mac(i, in_A, m_ac[i], in_B, d, ov);
      if (cfg_lat[i] == 1) begin
        cv = valid_in; cd = d; co = ov;
      end else begin
        cv = p_v[i]; cd = p_d[i]; co = p_o[i];
        p_v[i] = valid_in; p_d[i] = d; p_o[i] = ov;
      end
      m_vo[i] = cv;
      if (cv) m_D[i] = cd;
      if (cv && co) m_ov[i] = 1;
      else if (ovf_clr) m_ov[i] = 0;
      if (wt_swap) m_ac[i] = m_sh[i];
      if (wt_en) m_sh[i] = wt_in;
      m_R[i] = in_A;
      m_vr[i] = valid_in;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("u%0d out_D", i), o_D[i], m_D[i]);
        check($sformatf("u%0d valid_out", i), 32'(o_vo[i]), 32'(m_vo[i]));
        check($sformatf("u%0d ovf", i), 32'(o_ov[i]), 32'(m_ov[i]));
        check($sformatf("u%0d out_R", i), 32'(o_R[i]), 32'(m_R[i]));
        check($sformatf("u%0d valid_r", i), 32'(o_vr[i]), 32'(m_vr[i]));
        check($sformatf("u%0d wt_out", i), 32'(o_wt[i]), 32'(m_sh[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic load_swap(input logic [7:0] w);
    wt_in = w; wt_en = 1; tick();
    wt_en = 0; wt_swap = 1; tick();
    wt_swap = 0;
  endtask

  typedef struct {
    logic [7:0]  w;
    logic [7:0]  a;
    logic [31:0] b;
  } vec_t;

  vec_t tbl [3] = '{'{8'h80, 8'h7F, 32'h8000_0000}, '{8'hFF, 8'hFF, 32'hFFFF_FFFF},
                    '{8'h10, 8'h80, 32'h0000_1234}};
  bit vr_exp [6] = '{1, 1, 0, 1, 0, 0};
  bit vo_exp [6] = '{0, 1, 1, 0, 1, 0};

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 0; wt_en = 0; wt_swap = 0; valid_in = 0; ovf_clr = 0;
    wt_in = '0; in_A = '0; in_B = '0;
    model_reset();
    cmp_en = 1;
    tick(); tick();
    check("reset out_D", o_D[0], 32'h0);
    check("reset ovf", 32'(o_ov[0]), 32'h0);
    check("reset valid_out", 32'(o_vo[4]), 32'h0);
    rst_n = 1;

    // Double buffer: weight 3 stays active while 7 loads into the shadow.
    load_swap(8'd3);
    wt_in = 8'd7; wt_en = 1; valid_in = 1; in_A = 8'd2; in_B = 32'd1;
    tick(); tick();
    check("dbuf hold u0", o_D[0], 32'd7);
    check("dbuf hold u4", o_D[4], 32'd7);
    wt_en = 0; wt_swap = 1;
    tick();
    check("swap same-cycle op", o_D[0], 32'd7);
    wt_swap = 0;
    tick();
    check("after swap", o_D[0], 32'd15);
    valid_in = 0; wt_in = 8'd9; wt_en = 1; wt_swap = 1;
    tick();
    check("en+swap shadow", 32'(o_wt[0]), 32'd9);
    wt_en = 0; wt_swap = 0; valid_in = 1; in_A = 8'd1; in_B = 32'd0;
    tick();
    check("en+swap active", o_D[0], 32'd7);
    valid_in = 0;
    tick();

    // Signed versus unsigned interpretation of the same operands.
    load_swap(8'd5);
    valid_in = 1; in_A = 8'hFD; in_B = 32'd10;
    tick();
    valid_in = 0;
    check("signed -3*5+10", o_D[0], 32'hFFFF_FFFB);
    check("signed ovf", 32'(o_ov[0]), 32'h0);
    check("unsigned 253*5+10", o_D[1], 32'd1275);
    tick();

    // 16-bit overflow: clamp versus wrap, and set-beats-clear.
    load_swap(8'd127);
    valid_in = 1; in_A = 8'd127; in_B = 32'h0000_7FF0;
    tick();
    check("sat16 out_D", o_D[2], 32'h7FFF);
    check("sat16 ovf", 32'(o_ov[2]), 32'h1);
    check("wrap16 out_D", o_D[3], 32'hBEF1);
    check("wrap16 ovf", 32'(o_ov[3]), 32'h1);
    check("wide no ovf", o_D[0], 32'hBEF1);
    ovf_clr = 1;
    tick();
    check("set beats clear", 32'(o_ov[2]), 32'h1);
    valid_in = 0;
    tick(); tick();
    check("clear", 32'(o_ov[2]), 32'h0);
    ovf_clr = 0;

    foreach (tbl[k]) begin
      load_swap(tbl[k].w);
      valid_in = 1; in_A = tbl[k].a; in_B = tbl[k].b;
      tick();
      valid_in = 0;
      if (k == 0) check("sat32 min", o_D[0], 32'h8000_0000);
      if (k == 1) check("usat32 max", o_D[1], 32'hFFFF_FFFF);
      if (k == 2) check("unsigned 16*128+0x1234", o_D[1], 32'h0000_1A34);
      tick(); tick();
    end
    ovf_clr = 1; tick(); ovf_clr = 0; tick();

    // Valid pulses at cycles 0,1,3 through the two-stage instance.
    for (int k = 0; k < 6; k++) begin
      valid_in = (k == 0) || (k == 1) || (k == 3);
      in_A = 8'(k + 1); in_B = '0;
      tick();
      check($sformatf("lat valid_r %0d", k), 32'(o_vr[4]), 32'(vr_exp[k]));
      check($sformatf("lat valid_out %0d", k), 32'(o_vo[4]), 32'(vo_exp[k]));
    end
    valid_in = 0;

    // Reset dropped mid-burst.
    valid_in = 1; in_A = 8'd1; in_B = 32'd5;
    tick(); tick();
    #1 rst_n = 0;
    model_reset();
    #1;
    check("rst out_D", o_D[4], 32'h0);
    check("rst valid_out", 32'(o_vo[4]), 32'h0);
    check("rst out_R", 32'(o_R[4]), 32'h0);
    check("rst valid_r", 32'(o_vr[4]), 32'h0);
    tick();
    rst_n = 1; valid_in = 0;
    tick();
    check("post-rst valid_out", 32'(o_vo[4]), 32'h0);
    valid_in = 1; in_A = 8'd4; in_B = 32'd100;
    tick();
    valid_in = 0;
    check("post-rst weight 0 u0", o_D[0], 32'd100);
    tick();
    check("post-rst weight 0 u4", o_D[4], 32'd100);

    // Daisy-chained load: first value ends up at the bottom.
    wt_en = 1;
    wt_in = 8'd10; tick();
    wt_in = 8'd20; tick();
    wt_in = 8'd30; tick();
    wt_en = 0;
    check("chain top", 32'(c_wt[0]), 32'd30);
    check("chain mid", 32'(c_wt[1]), 32'd20);
    check("chain bottom", 32'(c_wt[2]), 32'd10);
    tick();

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_dbuf.md
Name: pe_dbuf

Overview:
Next-generation weight-stationary processing element for the systolic array. Adds a shadow/active double-buffered weight so a new weight loads while the current one computes. Also adds a daisy-chained weight-load path down each column, selectable signed/unsigned arithmetic, an optional pipelined multiplier, saturating accumulation with a sticky overflow flag, and valid propagation in both array directions.

Parameters:
DATAWIDTH, 8, width of in_A, weights and out_R
DATAWIDTH_output, 32, width of in_B and out_D (must be >= 2*DATAWIDTH)
SIGNED, 1, 1 = two's-complement operands; 0 = unsigned
MUL_STAGES, 1, compute latency in cycles; legal values 1 or 2
SATURATE, 1, 1 = clamp sum to out_D range; 0 = wrap modulo 2^DATAWIDTH_output

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wt_en  in  1  shift wt_in into the shadow weight
wt_in  in  DATAWIDTH  weight from the PE above, or from the loader for row 0
wt_out  out  DATAWIDTH  shadow weight, driven directly from the register, to the PE below
wt_swap  in  1  copy shadow weight to active weight
valid_in  in  1  in_A/in_B valid this cycle
in_A  in  DATAWIDTH  activation from the left
in_B  in  DATAWIDTH_output  partial sum from above
out_D  out  DATAWIDTH_output  partial sum to the PE below
valid_out  out  1  out_D updated this cycle
out_R  out  DATAWIDTH  activation to the right
valid_r  out  1  out_R valid (valid_in delayed by 1 cycle)
ovf  out  1  sticky overflow/saturation flag
ovf_clr  in  1  clear ovf

Behaviour:
- Reset (async, rst_n=0): shadow, active, out_D, out_R, valid_out, valid_r, ovf and all pipeline registers go to 0. Reset asserted mid-operation discards in-flight data and valid_out is 0 on the cycle after release.
- Shadow weight: shadow <= wt_in when wt_en=1, otherwise hold. wt_out = shadow. A column of N PEs loads in N wt_en cycles, bottom row's value first.
- Active weight: active <= shadow when wt_swap=1. With wt_en and wt_swap in the same cycle, active takes the old shadow and shadow takes wt_in.
- Operand capture: valid_in=1 samples in_A, in_B and the current active weight. A swap in the same cycle does not affect that operation; the new weight applies from the next valid_in.
- Horizontal path: out_R <= in_A and valid_r <= valid_in every cycle, unconditionally. Latency is 1 cycle for any MUL_STAGES.
- Vertical path:
  - MUL_STAGES=1: out_D <= f(in_A*active + in_B) in the valid_in cycle; valid_out <= valid_in.
  - MUL_STAGES=2: stage 1 registers the product, in_B and a valid bit; stage 2 registers the sum. valid_out is valid_in delayed 2 cycles.
  - out_D holds its value when no valid operation completes.
  - Back-to-back valid_in: one result per cycle, no bubbles.
- Arithmetic:
  - Product is 2*DATAWIDTH bits, sign- or zero-extended per SIGNED to DATAWIDTH_output+1 bits.
  - Sum uses DATAWIDTH_output+1 bits.
  - Overflow: the sum falls outside [-2^(W-1), 2^(W-1)-1] when signed, or exceeds 2^W-1 when unsigned, with W = DATAWIDTH_output.
  - SATURATE=1: overflow clamps to the nearest bound. SATURATE=0: keep the low W bits.
- ovf: set on any completing valid operation that overflows, in either SATURATE mode. Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.

Decomposition:
- Package pe_pkg holds:
  - the pe_mode_e enum (UNSIGNED/SIGNED)
  - localparam PROD_W = 2*DATAWIDTH default
  - a sat_bounds helper function that returns max/min for (width, signed).
- Sub-module pe_mac_sat: combinational multiply-extend-add-clamp with an overflow output. pe_dbuf instantiates it and wraps the pipeline registers around it.

Test Plan:
- Double buffer:
  - wt_in=3, wt_en, wt_swap. Then wt_in=7, wt_en while streaming A=2, B=1 each cycle → out_D=7 throughout (weight 3 active).
  - After wt_swap, the next valid → out_D=15.
  - Same-cycle wt_en+wt_swap → active=old shadow.
- Weight chain: 3 chained PEs, wt_en for 3 cycles with wt_in=10,20,30 → shadows bottom..top = 10,20,30; wt_out of top PE = 30.
- Signed: SIGNED=1, active=5, A=0xFD (-3), B=10 → out_D=0xFFFFFFFB (-5), ovf=0. The same operands with SIGNED=0 → 253*5+10 = 1275.
- Saturation:
  - DATAWIDTH_output=16, SIGNED=1, active=127, A=127, B=0x7FF0 → SATURATE=1 gives out_D=0x7FFF, ovf=1; SATURATE=0 gives out_D=0xBEF1, ovf=1.
  - ovf_clr and a new overflow in the same cycle → ovf stays 1.
- Latency/valid: MUL_STAGES=2, valid_in pulses at cycles 0,1,3 → valid_out high at cycles 2,3,5; valid_r at 1,2,4; out_D holds between.
- Reset mid-stream: drop rst_n during a burst with MUL_STAGES=2 → all outputs 0 immediately. After release with valid_in=0, valid_out stays 0 and active weight reads 0 (a later valid op gives out_D=in_B).
